// File: rtl/uart_bram_responder.sv
// Responder for the row/column BRAM read protocol over an 8N1 UART link.
// Optional ROW->COL timeout is built only when UART_RESP_TIMEOUT_EN is defined.
module uart_bram_responder #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter logic [15:0] BPS_NUM        = 16'd434,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_340_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic       resp_enable,
    output logic       bram_rd_en,
    output logic [9:0] bram_rd_addr,
    input  logic [7:0] bram_rd_data,
    output logic [15:0] req_cnt,
    output logic       proto_err,
    output logic       busy
);

    // A zero BPS_NUM falls back to the value derived from the clock and baud rate.
    localparam logic [15:0] BitCycles = (BPS_NUM != 16'd0) ? BPS_NUM
                                                           : 16'(CLK_FREQ / BAUD_RATE);
    localparam logic [15:0] BitLast   = BitCycles - 16'd1;
    localparam logic [15:0] HalfLast  = (BitCycles >> 1) - 16'd1;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {StIdle, StHaveRow, StRd, StRdWait, StTx} state_e;

    rx_state_e   rx_state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_vld_q;

    state_e      state_q;
    logic [4:0]  row_q;
    logic [8:0]  tx_shift_q;
    logic [15:0] tx_cnt_q;
    logic [3:0]  tx_bit_q;

    logic rx_stop_err;
    logic is_row, is_col, is_bad;

    assign rx_stop_err = (rx_state_q == RxStop) && (rx_cnt_q == BitLast) && !rx_sync_q;
    assign is_row      = rx_vld_q && (rx_shift_q[7:5] == 3'b000);
    assign is_col      = rx_vld_q && (rx_shift_q[7:5] == 3'b100);
    assign is_bad      = rx_vld_q && !is_row && !is_col;

    // Deserializer: every sample point is counted from the start-bit mid-point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_vld_q   <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_vld_q  <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= 16'd0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= 16'd0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= 16'd0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RxStop;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= 16'd0;
                        rx_state_q <= RxIdle;
                        rx_vld_q   <= rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

`ifdef UART_RESP_TIMEOUT_EN
    logic [31:0] to_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Request FSM; busy is high exactly in StRd, StRdWait and StTx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= 5'd0;
            tx_shift_q   <= 9'h1ff;
            tx_cnt_q     <= 16'd0;
            tx_bit_q     <= 4'd0;
            uart_tx      <= 1'b1;
            bram_rd_en   <= 1'b0;
            bram_rd_addr <= 10'd0;
            req_cnt      <= 16'd0;
            proto_err    <= 1'b0;
            busy         <= 1'b0;
`ifdef UART_RESP_TIMEOUT_EN
            to_cnt_q     <= 32'd0;
`endif
        end else begin
            bram_rd_en <= 1'b0;
            proto_err  <= rx_stop_err | is_bad | (rx_vld_q & busy);
            unique case (state_q)
                StIdle: begin
                    if (is_row) begin
                        row_q   <= rx_shift_q[4:0];
                        state_q <= StHaveRow;
`ifdef UART_RESP_TIMEOUT_EN
                        to_cnt_q <= 32'd0;
`endif
                    end else if (is_col) begin
                        proto_err <= 1'b1;
                    end
                end
                StHaveRow: begin
                    if (is_row) begin
                        row_q <= rx_shift_q[4:0];
`ifdef UART_RESP_TIMEOUT_EN
                        to_cnt_q <= 32'd0;
`endif
                    end else if (is_col) begin
                        if (resp_enable) begin
                            state_q      <= StRd;
                            bram_rd_en   <= 1'b1;
                            bram_rd_addr <= {row_q, rx_shift_q[4:0]};
                            busy         <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
`ifdef UART_RESP_TIMEOUT_EN
                    end else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                        state_q   <= StIdle;
                        row_q     <= 5'd0;
                        proto_err <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
`endif
                    end
                end
                StRd: state_q <= StRdWait;
                StRdWait: begin
                    tx_shift_q <= {1'b1, bram_rd_data};
                    uart_tx    <= 1'b0;
                    tx_cnt_q   <= 16'd0;
                    tx_bit_q   <= 4'd0;
                    state_q    <= StTx;
                end
                StTx: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q <= 16'd0;
                        if (tx_bit_q == 4'd9) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            req_cnt <= req_cnt + 16'd1;
                        end else begin
                            // The shifted-in 1 becomes the stop bit after data bit 7.
                            uart_tx    <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                            tx_bit_q   <= tx_bit_q + 4'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bram_responder.sv
// Self-checking bench for uart_bram_responder: vector table, corner sequences and
// randomized requests against a protocol-level model.
`timescale 1ns / 1ps
module tb_uart_bram_responder;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        resp_enable = 1'b1;
    logic        bram_rd_en;
    logic [9:0]  bram_rd_addr;
    logic [7:0]  bram_rd_data = 8'd0;
    logic [15:0] req_cnt;
    logic        proto_err;
    logic        busy;

    uart_bram_responder #(
        .CLK_FREQ      (50_000_000),
        .BAUD_RATE     (115200),
        .BPS_NUM       (16'(B)),
        .TIMEOUT_CYCLES(32'd1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .resp_enable (resp_enable),
        .bram_rd_en  (bram_rd_en),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data),
        .req_cnt     (req_cnt),
        .proto_err   (proto_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    always @(posedge clk) if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] exp_req = 16'd0;

    // Observers, sampled mid-cycle.
    int err_cnt = 0, rd_cnt = 0;
    int rd_cyc = 0, txfall_cyc = 0, busyfall_cyc = 0;
    logic busy_at_rd = 1'b0, armed = 1'b0, busy_prev = 1'b0;
    logic [9:0] rd_q [$];
    logic [8:0] tx_q [$];

    always @(negedge clk) begin
        if (proto_err === 1'b1) err_cnt++;
        if (bram_rd_en === 1'b1) begin
            rd_cnt++;
            rd_q.push_back(bram_rd_addr);
            rd_cyc = cyc;
            busy_at_rd = busy;
            armed = 1'b1;
        end else if (armed && uart_tx === 1'b0) begin
            txfall_cyc = cyc;
            armed = 1'b0;
        end
        if (busy_prev && busy === 1'b0) busyfall_cyc = cyc;
        busy_prev = (busy === 1'b1);
    end

    // Line decoder for the reply path: frames stored as {stop, data}.
    logic [7:0] dec_d;
    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                repeat (B / 2 - 1) @(negedge clk);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (B) @(negedge clk);
                        dec_d[i] = uart_tx;
                    end
                    repeat (B) @(negedge clk);
                    tx_q.push_back({uart_tx, dec_d});
                end
            end
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int stop_len);
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (B) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (B) @(posedge clk); #1;
        end
        uart_rx = stop_ok;
        repeat (stop_len) @(posedge clk); #1;
        uart_rx = 1'b1;
        if (!stop_ok) repeat (B) @(posedge clk);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy === 1'b1 && i < 20 * B) begin
            @(posedge clk); #1;
            i++;
        end
        check("busy_release", {31'b0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input logic [9:0] addr);
        logic [9:0] a;
        logic [8:0] f;
        check("rd_q_size", rd_q.size(), 32'd1);
        if (rd_q.size() > 0) begin
            a = rd_q.pop_front();
            check("rd_addr", {22'b0, a}, {22'b0, addr});
        end
        check("tx_q_size", tx_q.size(), 32'd1);
        if (tx_q.size() > 0) begin
            f = tx_q.pop_front();
            check("tx_frame", {23'b0, f}, {23'b0, 1'b1, mem[addr]});
        end
        exp_req = exp_req + 16'd1;
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        bit         en;
        logic [7:0] mem_val;
        bit         exp_rd;
        logic [9:0] exp_addr;
        int         exp_err;
    } vec_t;

    vec_t vecs [7];
    logic [7:0] seq [$];
    logic [9:0] mexp [$];

    initial begin
        int e0, r0, m_err, k, c;
        bit en, have;
        logic [4:0] m_row;

        vecs[0] = '{2, 8'h03, 8'h85, 8'h00, 1'b1, 8'hA7, 1'b1, 10'h065, 0};
        vecs[1] = '{3, 8'h01, 8'h1F, 8'h9F, 1'b1, 8'h5A, 1'b1, 10'h3FF, 0};
        vecs[2] = '{1, 8'h81, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 10'h000, 1};
        vecs[3] = '{1, 8'h40, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 10'h000, 1};
        vecs[4] = '{3, 8'h07, 8'h88, 8'h88, 1'b0, 8'h00, 1'b0, 10'h000, 1};
        vecs[5] = '{3, 8'h0A, 8'hE0, 8'h81, 1'b1, 8'h3C, 1'b1, 10'h141, 1};
        vecs[6] = '{2, 8'h00, 8'h80, 8'h00, 1'b1, 8'h11, 1'b1, 10'h000, 0};

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        // Reset values
        repeat (3) @(posedge clk); #1;
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_rd_en", {31'b0, bram_rd_en}, 32'd0);
        check("rst_rd_addr", {22'b0, bram_rd_addr}, 32'd0);
        check("rst_req_cnt", {16'b0, req_cnt}, 32'd0);
        check("rst_proto_err", {31'b0, proto_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Reset in the middle of a reply frame
        mem[10'h065] = 8'hA7;
        send_byte(8'h03, 1'b1, B);
        send_byte(8'h85, 1'b1, B);
        repeat (3 * B) @(posedge clk);
        #2;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_rd_en", {31'b0, bram_rd_en}, 32'd0);
        check("midrst_proto_err", {31'b0, proto_err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (12 * B) @(posedge clk);
        #1;
        check("midrst_req_cnt", {16'b0, req_cnt}, 32'd0);
        rd_q.delete();
        tx_q.delete();

        // Basic request with latency and frame-length checks
        e0 = err_cnt; r0 = rd_cnt;
        send_byte(8'h03, 1'b1, B);
        send_byte(8'h85, 1'b1, B);
        wait_idle();
        check("lat_busy_at_rd", {31'b0, busy_at_rd}, 32'd1);
        check("lat_rd_to_start", txfall_cyc - rd_cyc, 32'd2);
        check("lat_frame_len", busyfall_cyc - txfall_cyc, 10 * B);
        check("basic_rd_cnt", rd_cnt - r0, 32'd1);
        check("basic_err", err_cnt - e0, 32'd0);
        expect_read(10'h065);
        check("basic_req_cnt", {16'b0, req_cnt}, {16'b0, exp_req});

        // Vector table
        for (int i = 0; i < 7; i++) begin
            resp_enable = vecs[i].en;
            if (vecs[i].exp_rd) mem[vecs[i].exp_addr] = vecs[i].mem_val;
            e0 = err_cnt; r0 = rd_cnt;
            send_byte(vecs[i].b0, 1'b1, B);
            wait_idle();
            if (vecs[i].n > 1) begin send_byte(vecs[i].b1, 1'b1, B); wait_idle(); end
            if (vecs[i].n > 2) begin send_byte(vecs[i].b2, 1'b1, B); wait_idle(); end
            check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_rd", i), rd_cnt - r0, {31'b0, vecs[i].exp_rd});
            if (vecs[i].exp_rd) expect_read(vecs[i].exp_addr);
            else check($sformatf("vec%0d_no_tx", i), tx_q.size(), 32'd0);
            check($sformatf("vec%0d_req_cnt", i), {16'b0, req_cnt}, {16'b0, exp_req});
        end
        resp_enable = 1'b1;

        // Framing error drops the ROW, so the following COL lands in IDLE
        e0 = err_cnt; r0 = rd_cnt;
        send_byte(8'h03, 1'b0, B);
        check("stop0_err", err_cnt - e0, 32'd1);
        send_byte(8'h85, 1'b1, B);
        wait_idle();
        check("stop0_col_err", err_cnt - e0, 32'd2);
        check("stop0_rd", rd_cnt - r0, 32'd0);
        check("stop0_no_tx", tx_q.size(), 32'd0);

        // Quarter-bit glitch is ignored
        e0 = err_cnt; r0 = rd_cnt;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (B / 4) @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (12 * B) @(posedge clk);
        check("glitch_err", err_cnt - e0, 32'd0);
        check("glitch_rd", rd_cnt - r0, 32'd0);

        // Byte arriving during the reply; short stop bit lets it land inside TX
        mem[10'h044] = 8'hC3;
        e0 = err_cnt; r0 = rd_cnt;
        send_byte(8'h02, 1'b1, B);
        send_byte(8'h84, 1'b1, B / 2 + 8);
        send_byte(8'h00, 1'b1, B);
        wait_idle();
        check("intx_err", err_cnt - e0, 32'd1);
        check("intx_rd", rd_cnt - r0, 32'd1);
        expect_read(10'h044);
        check("intx_req_cnt", {16'b0, req_cnt}, {16'b0, exp_req});
        send_byte(8'h88, 1'b1, B);
        wait_idle();
        check("intx_idle_after", err_cnt - e0, 32'd2);
        check("intx_no_extra_rd", rd_cnt - r0, 32'd1);

        // ROW followed by a long gap before COL
        e0 = err_cnt; r0 = rd_cnt;
        send_byte(8'h05, 1'b1, B);
        repeat (1001) @(posedge clk);
        send_byte(8'h83, 1'b1, B);
        wait_idle();
`ifdef UART_RESP_TIMEOUT_EN
        check("tmo_err", err_cnt - e0, 32'd2);
        check("tmo_rd", rd_cnt - r0, 32'd0);
        check("tmo_no_tx", tx_q.size(), 32'd0);
`else
        check("tmo_err", err_cnt - e0, 32'd0);
        check("tmo_rd", rd_cnt - r0, 32'd1);
        expect_read(10'h0A3);
`endif
        check("tmo_req_cnt", {16'b0, req_cnt}, {16'b0, exp_req});

        // Randomized requests against the protocol model
        for (int it = 0; it < 16; it++) begin
            seq.delete();
            mexp.delete();
            en = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) seq.push_back({3'b000, 5'($urandom)});
            if ($urandom_range(0, 1) == 1) begin
                c = $urandom_range(1, 6);
                if (c >= 4) c++;
                seq.insert($urandom_range(0, seq.size()), {3'(c), 5'($urandom)});
            end
            seq.push_back({3'b100, 5'($urandom)});

            have = 1'b0; m_row = 5'd0; m_err = 0;
            foreach (seq[j]) begin
                if (seq[j][7:5] == 3'b000) begin
                    have = 1'b1;
                    m_row = seq[j][4:0];
                end else if (seq[j][7:5] == 3'b100) begin
                    if (!have) m_err++;
                    else if (en) mexp.push_back({m_row, seq[j][4:0]});
                    have = 1'b0;
                end else begin
                    m_err++;
                end
            end

            resp_enable = en;
            e0 = err_cnt; r0 = rd_cnt;
            foreach (seq[j]) begin
                send_byte(seq[j], 1'b1, B);
                wait_idle();
            end
            check($sformatf("rnd%0d_err", it), err_cnt - e0, m_err);
            check($sformatf("rnd%0d_rd", it), rd_cnt - r0, mexp.size());
            if (mexp.size() > 0) expect_read(mexp[0]);
            else check($sformatf("rnd%0d_no_tx", it), tx_q.size(), 32'd0);
            check($sformatf("rnd%0d_req_cnt", it), {16'b0, req_cnt}, {16'b0, exp_req});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_bram_responder.md
# uart_bram_responder

Responder end of the row/column BRAM request protocol. It receives UART request bytes, a ROW byte `{3'b000,row[4:0]}` followed by a COL byte `{3'b100,col[4:0]}`. It then reads the 8-bit word at BRAM address `{row,col}` and returns that word as a single UART byte. The block contains its own 8N1 deserializer and serializer and drives a registered BRAM read port. It sits on the FPGA/PC-emulator side of the link, opposite the BRAM-write request initiator.

## Interface
- `CLK_FREQ`, default 50_000_000, system clock in Hz.
- `BAUD_RATE`, default 115200, line rate.
- `BPS_NUM`, default 16'd434, clocks per bit (CLK_FREQ/BAUD_RATE).
- `TIMEOUT_CYCLES`, default 32'd4_340_000, ROW→COL timeout in clocks (used only with the timeout macro).
- `clk` input 1: the only clock. All logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `uart_rx` input 1: serial input, idle high, asynchronous to `clk`.
- `uart_tx` output 1: serial output, idle high.
- `resp_enable` input 1: when low, requests are decoded and discarded with no BRAM read and no reply.
- `bram_rd_en` output 1: one-cycle read strobe.
- `bram_rd_addr` output 10: `{row,col}`, held stable until the next read.
- `bram_rd_data` input 8: valid the cycle after `bram_rd_en`.
- `req_cnt` output 16: number of completed replies, wraps at 0xFFFF→0.
- `proto_err` output 1: one-cycle pulse on any protocol or framing error.
- `busy` output 1: high from COL acceptance until the reply stop bit completes.

## Operation
- Reset values: `uart_tx`=1, `bram_rd_en`=0, `bram_rd_addr`=0, `req_cnt`=0, `proto_err`=0, `busy`=0, FSM=IDLE, row register cleared.
- RX path:
  - `uart_rx` passes through a 2-FF synchronizer. A falling edge starts a frame.
  - The start bit is re-checked at BPS_NUM/2. If it is high, the frame is treated as a glitch and dropped silently.
  - Data bits are sampled LSB first, every BPS_NUM clocks from the start mid-point. The stop bit is sampled the same way.
  - If the stop bit is 0, the byte is dropped and `proto_err` pulses.
  - A good byte produces an internal one-cycle `rx_vld`.
- Decode by byte[7:5]: 000=ROW, 100=COL. Any other code is dropped and `proto_err` pulses.
- FSM states:
  - IDLE: ROW stores the row and moves to HAVE_ROW. COL moves to IDLE and pulses `proto_err`.
  - HAVE_ROW: ROW overwrites the row and stays. COL with `resp_enable`=1 moves to RD. COL with `resp_enable`=0 moves to IDLE with no error.
  - RD: `bram_rd_en`=1 for exactly one cycle, `bram_rd_addr`={row,col}. Next state RD_WAIT.
  - RD_WAIT: captures `bram_rd_data` into the TX shift register. Next state TX.
  - TX: sends start bit, 8 data bits LSB first, then stop bit, each BPS_NUM clocks. At the end of the stop bit: `req_cnt`+1, move to IDLE.
- Any byte completing while in RD, RD_WAIT or TX is dropped and `proto_err` pulses. The RX deserializer keeps running in all states.
- `rst` asserted at any point, including mid-frame on RX or TX, returns every output to its reset value immediately. Any partial reply is abandoned.

## Timing
- T = cycle of `rx_vld` for an accepted COL byte. Then:
  - `busy`↑ and `bram_rd_en`=1 at T+1.
  - Data captured at T+2.
  - `uart_tx` falls (start bit) at T+3.
- Reply frame length is 10×BPS_NUM clocks. `busy`↓, `req_cnt` updated, and IDLE reached in the same cycle the stop bit ends.
- `proto_err` is registered and asserts the cycle after the offending `rx_vld` or stop-bit sample.
- Back-to-back: a ROW byte may be accepted in the first IDLE cycle after a reply.

## Configuration
- `UART_RESP_TIMEOUT_EN` defined:
  - A counter starts on ROW acceptance and restarts on each ROW overwrite.
  - If it reaches TIMEOUT_CYCLES while in HAVE_ROW, the FSM moves to IDLE, `proto_err` pulses and the row is discarded.
- `UART_RESP_TIMEOUT_EN` not defined: no counter is built, and HAVE_ROW waits indefinitely. TIMEOUT_CYCLES is ignored.

## Test plan
- Reset: assert `rst` during a reply frame → `uart_tx`=1, `busy`=0, `bram_rd_en`=0 within the same cycle. Check `req_cnt` stays 0.
- Basic request: send 0x03 then 0x85; BRAM model returns 0xA7 → one `bram_rd_en` pulse with `bram_rd_addr`=0x065. Expect `uart_tx` frame 0xA7 starting at T+3 and `req_cnt`=1.
- Row overwrite: send 0x01, then 0x1F, then 0x9F; BRAM returns 0x5A → `bram_rd_addr`=0x3FF, reply 0x5A, no `proto_err`.
- Errors:
  - Send 0x81 in IDLE → `proto_err` pulse, no read.
  - Send 0x40 → `proto_err` pulse.
  - Send a frame with stop bit 0 → `proto_err`, byte dropped.
  - Send a 0.25-bit low glitch → no `proto_err`.
- Byte during TX: send 0x02, 0x84, then 0x00 while the reply is in flight → `proto_err` pulse, reply intact, FSM IDLE afterwards.
- Timeout, macro defined, TIMEOUT_CYCLES=1000: send 0x05, idle 1001 cycles, then send 0x83 → two `proto_err` pulses, no read, `req_cnt` unchanged. With the macro undefined, the same stimulus gives a reply from address 0x0A3.
